cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter: SETS, default 16384, number of cache sets.
REQ-002 Parameter: WAYS, default 8, associativity; LRU field encodes ranks 0..WAYS-1.
REQ-003 Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  trace command present.
- cmd_ready  out  1  controller accepts cmd.
- cmd  in  command_t  trace command (n, address with tag/set_index).
- instruction  out  command_t  command driven to cache.
- read_enable  out  1  cache set read strobe.
- write_enable  out  1  cache set write strobe.
- cache_rd_data  in  cache_line_t[1][WAYS]  set contents returned by cache.
- cache_wr_data  out  cache_line_t[1][WAYS]  updated set written to cache.
- hit  out  1  one-cycle pulse: lookup hit.
- miss  out  1  one-cycle pulse: lookup miss.
- done  out  1  one-cycle pulse: command retired.
- read_count, write_count, hit_count, miss_count  out  32 each  statistics (STATS_EN only).

Function
REQ-004 FSM states IDLE, READ, UPDATE, WRITE; encoding is free.
REQ-005 IDLE: cmd_ready=1; cmd_valid&cmd_ready captures cmd into instruction register; next state READ, except n=8 -> WRITE and unknown n (5,6,7,10-15) -> IDLE with done pulse.
REQ-006 READ (1 cycle): read_enable=1, instruction held stable; cache_rd_data registered at end of cycle; next UPDATE.
REQ-007 UPDATE (1 cycle): compute hit (any way with MESI!=I and tag match), hit way, victim, new MESI and LRU into cache_wr_data; hit/miss pulse here for n=0,1,2 only.
REQ-008 Victim selection on miss: lowest-index way with MESI=I; if none, way with LRU=WAYS-1.
REQ-009 LRU on access (n=0,1,2): accessed way LRU=0; every way with LRU < accessed way's previous LRU increments; others unchanged; ranks remain a permutation of 0..WAYS-1.
REQ-010 MESI: n=0/2 miss -> E, n=0/2 hit -> unchanged; n=1 hit or miss -> M; n=3 hit -> I (LRU unchanged); n=4 hit in M or E -> S (LRU unchanged); n=3/4 miss -> no change.
REQ-011 Fill on miss: tag = cmd tag, data = 0; hit leaves data unchanged.
REQ-012 UPDATE next state: WRITE if set changed; IDLE with done pulse for n=9, n=3/4 miss, or n=4 hit in S/I.
REQ-013 WRITE (1 cycle): write_enable=1, cache_wr_data valid; done=1; next IDLE.
REQ-014 Latency accept->done: 3 cycles for n=0..4 with write, 2 cycles without write, 1 cycle for n=8; at most one command in flight.
REQ-015 read_enable and write_enable never asserted in the same cycle.
REQ-016 cmd_ready=0 in all states except IDLE; cmd is ignored while cmd_ready=0.

Reset
REQ-017 rst sampled on posedge clk; forces IDLE in the next cycle, aborting any in-flight command with no write_enable issued.
REQ-018 Reset values: cmd_ready=1 after reset release, read_enable=0, write_enable=0, hit=0, miss=0, done=0, instruction=0, cache_wr_data=0, all counters=0.

Configuration
REQ-019 Macro CACHE_CTRL_STATS_EN: defined -> counters present; n=0/2 increments read_count, n=1 increments write_count, hit/miss pulses increment hit_count/miss_count; n=8 clears all counters; counters wrap at 2^32.
REQ-020 Macro undefined -> counter ports remain and are tied to 0; no counter flops.

Verification
REQ-021 Reset, then n=0 addr 0x0000_0040 (set 1) on empty set -> miss, way 0 written E, tag 0, LRU 0, done 3 cycles after accept.
REQ-022 Same read again -> hit, no MESI change, LRU unchanged, read_count=2, hit_count=1.
REQ-023 Nine n=0 reads, distinct tags, set 5 -> 9th evicts way whose LRU=7 (first-filled line); LRU ranks remain a permutation.
REQ-024 n=1 to E line, then n=4 same address -> M then S; n=3 -> I, write_enable asserted each time.
REQ-025 n=9 -> read_enable only, no write_enable, done after 2 cycles; n=8 -> write_enable with n=8, counters 0.
REQ-026 rst asserted during READ -> IDLE next cycle, no write_enable, cmd_ready=1 after release.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: trace-driven set-associative cache controller, one command in flight (IDLE/READ/UPDATE/WRITE).
// Optional statistics counters are built when CACHE_CTRL_STATS_EN is defined; otherwise the ports read 0.
package cache_ctrl_pkg;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int SET_W    = 14;
    localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W;
    localparam int LRU_W    = 3;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [SET_W-1:0]    set_index;
        logic [OFFSET_W-1:0] offset;
    } addr_t;

    typedef struct packed {
        logic [3:0] n;
        addr_t      address;
    } command_t;

    typedef struct packed {
        mesi_t             mesi;
        logic [LRU_W-1:0]  lru;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cache_line_t;
endpackage

module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int SETS = 16384,
    parameter int WAYS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  command_t                cmd,
    output command_t                instruction,
    output logic                    read_enable,
    output logic                    write_enable,
    input  cache_line_t [WAYS-1:0]  cache_rd_data,
    output cache_line_t [WAYS-1:0]  cache_wr_data,
    output logic                    hit,
    output logic                    miss,
    output logic                    done,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int WAYS_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_UPDATE, S_WRITE} state_t;

    state_t                  state, state_d;
    command_t                instr_q, cmd_in;
    cache_line_t [WAYS-1:0]  rd_q, wr_q, new_set;
    logic                    bad_q;
    logic [WAYS-1:0]         hit_vec, inv_vec;
    logic                    lookup_hit, access, set_changed;
    logic [WAYS_W-1:0]       hit_way, victim, acc_way;
    logic [LRU_W-1:0]        acc_lru;

    // Commands that go through the read-modify-write lookup path.
    function automatic logic is_lookup(input logic [3:0] n);
        return (n <= 4'd4) || (n == 4'd9);
    endfunction

    always_comb begin
        cmd_in = cmd;
        cmd_in.address.set_index = cmd.address.set_index & SET_W'(SETS - 1);
    end

    assign access = (instr_q.n <= 4'd2);

    // Lookup and next-set computation on the registered set contents.
    always_comb begin
        hit_vec = '0;
        inv_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = (rd_q[w].mesi != MESI_I) && (rd_q[w].tag == instr_q.address.tag);
            inv_vec[w] = (rd_q[w].mesi == MESI_I);
        end
        lookup_hit = |hit_vec;

        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (hit_vec[w]) hit_way = WAYS_W'(w);

        // LRU way first, then any invalid way overrides, lowest index winning.
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (rd_q[w].lru == LRU_W'(WAYS - 1)) victim = WAYS_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (inv_vec[w]) victim = WAYS_W'(w);

        acc_way = lookup_hit ? hit_way : victim;
        acc_lru = rd_q[acc_way].lru;

        new_set = rd_q;
        case (instr_q.n)
            4'd0, 4'd1, 4'd2: begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAYS_W'(w) == acc_way)
                        new_set[w].lru = '0;
                    else if (rd_q[w].lru < acc_lru)
                        new_set[w].lru = rd_q[w].lru + LRU_W'(1);
                end
                if (!lookup_hit) begin
                    new_set[acc_way].tag  = instr_q.address.tag;
                    new_set[acc_way].data = '0;
                    new_set[acc_way].mesi = MESI_E;
                end
                if (instr_q.n == 4'd1) new_set[acc_way].mesi = MESI_M;
            end
            4'd3: if (lookup_hit) new_set[hit_way].mesi = MESI_I;
            4'd4: if (lookup_hit && (rd_q[hit_way].mesi == MESI_M || rd_q[hit_way].mesi == MESI_E))
                      new_set[hit_way].mesi = MESI_S;
            default: ;
        endcase
        set_changed = (new_set != rd_q);
    end

    always_comb begin
        state_d      = state;
        cmd_ready    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        hit          = 1'b0;
        miss         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                done      = bad_q;
                if (cmd_valid) begin
                    if (cmd.n == 4'd8)        state_d = S_WRITE;
                    else if (is_lookup(cmd.n)) state_d = S_READ;
                end
            end
            S_READ: begin
                read_enable = 1'b1;
                state_d     = S_UPDATE;
            end
            S_UPDATE: begin
                hit  = access && lookup_hit;
                miss = access && !lookup_hit;
                if (set_changed) begin
                    state_d = S_WRITE;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                write_enable = 1'b1;
                done         = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            bad_q   <= 1'b0;
        end else begin
            state <= state_d;
            bad_q <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    instr_q <= cmd_in;
                    bad_q   <= !is_lookup(cmd.n) && (cmd.n != 4'd8);
                    if (cmd.n == 4'd8) wr_q <= '0;
                end
                S_READ:   rd_q <= cache_rd_data;
                S_UPDATE: wr_q <= new_set;
                default: ;
            endcase
        end
    end

    assign instruction   = instr_q;
    assign cache_wr_data = wr_q;

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_WRITE && instr_q.n == 4'd8)) begin
            read_count  <= '0;
            write_count <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else if (state == S_UPDATE && access) begin
            if (instr_q.n == 4'd1) write_count <= write_count + 32'd1;
            else                   read_count  <= read_count + 32'd1;
            if (lookup_hit) hit_count  <= hit_count + 32'd1;
            else            miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign read_count  = '0;
    assign write_count = '0;
    assign hit_count   = '0;
    assign miss_count  = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: the bench plays the cache array and checks the controller against a recency-stamp model.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    localparam int WAYS = 8;
    localparam int NS   = 16;
`ifdef CACHE_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, cmd_valid, cmd_ready;
    command_t cmd, instruction;
    logic read_enable, write_enable, hit, miss, done;
    cache_line_t [WAYS-1:0] cache_rd_data, cache_wr_data;
    logic [31:0] read_count, write_count, hit_count, miss_count;

    always #5 clk = ~clk;

    cache_ctrl #(.SETS(16384), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .instruction(instruction), .read_enable(read_enable), .write_enable(write_enable),
        .cache_rd_data(cache_rd_data), .cache_wr_data(cache_wr_data),
        .hit(hit), .miss(miss), .done(done),
        .read_count(read_count), .write_count(write_count), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Cache array stand-in
    cache_line_t [WAYS-1:0] mem [NS];
    cache_line_t [WAYS-1:0] init_set [NS];
    logic mem_init;
    assign cache_rd_data = mem[instruction.address.set_index[3:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int s = 0; s < NS; s++) mem[s] <= init_set[s];
        end else if (write_enable && instruction.n != 4'd8) begin
            mem[instruction.address.set_index[3:0]] <= cache_wr_data;
        end
    end

    // Reference model: recency is a timestamp per way; rank = number of more recently used ways.
    logic [TAG_W-1:0]  m_tag  [NS][WAYS];
    mesi_t             m_mesi [NS][WAYS];
    logic [DATA_W-1:0] m_data [NS][WAYS];
    int                m_stamp[NS][WAYS];
    int                tick;
    logic [31:0]       m_rc, m_wc, m_hc, m_mc;
    int n_cmp, n_fail;

    function automatic int rank_of(input int s, input int w);
        int r = 0;
        for (int v = 0; v < WAYS; v++) if (m_stamp[s][v] > m_stamp[s][w]) r++;
        return r;
    endfunction

    task automatic model_cmd(input logic [3:0] n, input int s, input int tag,
                             output bit e_hit, output bit e_miss, output bit e_re, output bit e_we, output int e_lat);
        int way;
        bit hv, chg, lookup;
        way = -1;
        chg = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (way < 0 && m_mesi[s][w] != MESI_I && m_tag[s][w] == TAG_W'(tag)) way = w;
        hv = (way >= 0);
        lookup = (n <= 4'd4) || (n == 4'd9);
        if (n <= 4'd2) begin
            if (!hv) begin
                for (int w = 0; w < WAYS; w++) if (way < 0 && m_mesi[s][w] == MESI_I) way = w;
                if (way < 0) begin
                    way = 0;
                    for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][way]) way = w;
                end
                m_tag[s][way]  = TAG_W'(tag);
                m_data[s][way] = '0;
                m_mesi[s][way] = (n == 4'd1) ? MESI_M : MESI_E;
                chg = 1'b1;
            end else if (n == 4'd1 && m_mesi[s][way] != MESI_M) begin
                m_mesi[s][way] = MESI_M;
                chg = 1'b1;
            end
            if (rank_of(s, way) != 0) chg = 1'b1;
            tick++;
            m_stamp[s][way] = tick;
            if (n == 4'd1) m_wc++; else m_rc++;
            if (hv) m_hc++; else m_mc++;
        end else if (n == 4'd3) begin
            if (hv) begin m_mesi[s][way] = MESI_I; chg = 1'b1; end
        end else if (n == 4'd4) begin
            if (hv && (m_mesi[s][way] == MESI_M || m_mesi[s][way] == MESI_E)) begin
                m_mesi[s][way] = MESI_S; chg = 1'b1;
            end
        end else if (n == 4'd8) begin
            m_rc = '0; m_wc = '0; m_hc = '0; m_mc = '0;
        end
        e_hit  = (n <= 4'd2) && hv;
        e_miss = (n <= 4'd2) && !hv;
        e_re   = lookup;
        e_we   = chg || (n == 4'd8);
        e_lat  = !lookup ? 1 : (chg ? 3 : 2);
    endtask

    // Issues one command; while busy a different command stays on the bus with cmd_valid high.
    task automatic run_cmd(input logic [3:0] n, input int s, input int tag,
                           output int lat, output int nre, output int nwe, output int nhit, output int nmiss,
                           output int nboth, output int nrdy, output logic [3:0] wn);
        lat = 0; nre = 0; nwe = 0; nhit = 0; nmiss = 0; nboth = 0; nrdy = 0; wn = '0;
        @(negedge clk);
        cmd.n                 = n;
        cmd.address.tag       = TAG_W'(tag);
        cmd.address.set_index = SET_W'(s);
        cmd.address.offset    = OFFSET_W'($urandom);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd.n                 = 4'($urandom_range(0, 2));
        cmd.address.tag       = TAG_W'($urandom_range(0, 11));
        cmd.address.set_index = SET_W'($urandom_range(0, NS - 1));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (read_enable) nre++;
            if (write_enable) begin nwe++; wn = instruction.n; end
            if (read_enable && write_enable) nboth++;
            if (hit) nhit++;
            if (miss) nmiss++;
            if (cmd_ready) nrdy++;
            if (done) begin lat = k; cmd_valid = 1'b0; break; end
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    int lat, nre, nwe, nhit, nmiss, nboth, nrdy, e_lat;
    logic [3:0] wn;
    bit e_hit, e_miss, e_re, e_we;

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (read_enable !== 1'b0 || write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enables: got re=%b we=%b want 0 0", read_enable, write_enable); end
        n_cmp++; if ({hit, miss, done} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {hit, miss, done}); end
        n_cmp++; if (instruction !== '0) begin n_fail++; $display("FAIL reset_instruction: got %h want 0", instruction); end
        n_cmp++; if (cache_wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got nonzero want 0"); end
        n_cmp++; if ({read_count, write_count, hit_count, miss_count} !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d %0d %0d want 0", read_count, write_count, hit_count, miss_count); end
    endtask

    task automatic test_read_miss();
        run_cmd(4'd0, 1, 0, lat, nre, nwe, nhit, nmiss, nboth, nrdy, wn);
        model_cmd(4'd0, 1, 0, e_hit, e_miss, e_re, e_we, e_lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rdmiss_latency: got %0d want 3", lat); end
        n_cmp++; if (nmiss !== 1 || nhit !== 0) begin n_fail++; $display("FAIL rdmiss_pulse: got hit=%0d miss=%0d want 0 1", nhit, nmiss); end
        n_cmp++; if (nwe !== 1 || nre !== 1) begin n_fail++; $display("FAIL rdmiss_strobes: got re=%0d we=%0d want 1 1", nre, nwe); end
        n_cmp++; if (mem[1][0].mesi !== MESI_E || mem[1][0].tag !== '0 || mem[1][0].lru !== '0 || mem[1][0].data !== '0)
            begin n_fail++; $display("FAIL rdmiss_line: got mesi=%0d tag=%h lru=%0d data=%h want 2 0 0 0", mem[1][0].mesi, mem[1][0].tag, mem[1][0].lru, mem[1][0].data); end
    endtask

    task automatic test_read_hit();
        run_cmd(4'd0, 1, 0, lat, nre, nwe, nhit, nmiss, nboth, nrdy, wn);
        model_cmd(4'd0, 1, 0, e_hit, e_miss, e_re, e_we, e_lat);
        n_cmp++; if (nhit !== 1 || nmiss !== 0) begin n_fail++; $display("FAIL rdhit_pulse: got hit=%0d miss=%0d want 1 0", nhit, nmiss); end
        n_cmp++; if (lat !== 2 || nwe !== 0) begin n_fail++; $display("FAIL rdhit_nowrite: got lat=%0d we=%0d want 2 0", lat, nwe); end
        n_cmp++; if (mem[1][0].mesi !== MESI_E || mem[1][0].lru !== '0) begin n_fail++; $display("FAIL rdhit_line: got mesi=%0d lru=%0d want 2 0", mem[1][0].mesi, mem[1][0].lru); end
        n_cmp++; if (read_count !== (STATS ? 32'd2 : 32'd0) || hit_count !== (STATS ? 32'd1 : 32'd0))
            begin n_fail++; $display("FAIL rdhit_counts: got rd=%0d hit=%0d want %0d %0d", read_count, hit_count, STATS ? 2 : 0, STATS ? 1 : 0); end
    endtask

    task automatic test_evict();
        logic [WAYS-1:0] seen;
        for (int i = 0; i < 9; i++) begin
            run_cmd(4'd0, 5, 200 + i, lat, nre, nwe, nhit, nmiss, nboth, nrdy, wn);
            model_cmd(4'd0, 5, 200 + i, e_hit, e_miss, e_re, e_we, e_lat);
        end
        n_cmp++; if (nmiss !== 1 || nwe !== 1) begin n_fail++; $display("FAIL evict_miss: got miss=%0d we=%0d want 1 1", nmiss, nwe); end
        n_cmp++; if (mem[5][0].tag !== TAG_W'(208) || mem[5][0].lru !== '0) begin n_fail++; $display("FAIL evict_victim: got way0 tag=%0d lru=%0d want 208 0", mem[5][0].tag, mem[5][0].lru); end
        n_cmp++; if (mem[5][1].tag !== TAG_W'(201) || mem[5][1].lru !== 3'd7) begin n_fail++; $display("FAIL evict_next_lru: got way1 tag=%0d lru=%0d want 201 7", mem[5][1].tag, mem[5][1].lru); end
        seen = '0;
        for (int w = 0; w < WAYS; w++) seen[mem[5][w].lru] = 1'b1;
        n_cmp++; if (seen !== '1) begin n_fail++; $display("FAIL evict_permutation: got rank mask %b want all ones", seen); end
    endtask

    task automatic test_mesi();
        logic [3:0] seq [4];
        mesi_t want [4];
        seq  = '{4'd0, 4'd1, 4'd4, 4'd3};
        want = '{MESI_E, MESI_M, MESI_S, MESI_I};
        for (int i = 0; i < 4; i++) begin
            run_cmd(seq[i], 7, 3, lat, nre, nwe, nhit, nmiss, nboth, nrdy, wn);
            model_cmd(seq[i], 7, 3, e_hit, e_miss, e_re, e_we, e_lat);
            n_cmp++; if (mem[7][0].mesi !== want[i] || nwe !== 1 || lat !== 3)
                begin n_fail++; $display("FAIL mesi_step%0d: got mesi=%0d we=%0d lat=%0d want %0d 1 3", i, mem[7][0].mesi, nwe, lat, want[i]); end
        end
    endtask

    task automatic test_n9_n8();
        run_cmd(4'd9, 1, 0, lat, nre, nwe, nhit, nmiss, nboth, nrdy, wn);
        model_cmd(4'd9, 1, 0, e_hit, e_miss, e_re, e_we, e_lat);
        n_cmp++; if (lat !== 2 || nre !== 1 || nwe !== 0 || nhit !== 0) begin n_fail++; $display("FAIL n9: got lat=%0d re=%0d we=%0d hit=%0d want 2 1 0 0", lat, nre, nwe, nhit); end
        run_cmd(4'd8, 2, 0, lat, nre, nwe, nhit, nmiss, nboth, nrdy, wn);
        model_cmd(4'd8, 2, 0, e_hit, e_miss, e_re, e_we, e_lat);
        n_cmp++; if (lat !== 1 || nre !== 0 || nwe !== 1 || wn !== 4'd8) begin n_fail++; $display("FAIL n8: got lat=%0d re=%0d we=%0d n=%0d want 1 0 1 8", lat, nre, nwe, wn); end
        n_cmp++; if ({read_count, write_count, hit_count, miss_count} !== '0) begin n_fail++; $display("FAIL n8_clear: got %0d %0d %0d %0d want 0", read_count, write_count, hit_count, miss_count); end
    endtask

    task automatic test_unknown();
        run_cmd(4'd6, 3, 1, lat, nre, nwe, nhit, nmiss, nboth, nrdy, wn);
        model_cmd(4'd6, 3, 1, e_hit, e_miss, e_re, e_we, e_lat);
        n_cmp++; if (lat !== 1 || nre !== 0 || nwe !== 0) begin n_fail++; $display("FAIL unknown_n: got lat=%0d re=%0d we=%0d want 1 0 0", lat, nre, nwe); end
    endtask

    task automatic test_reset_mid();
        int bad_we;
        @(negedge clk);
        cmd.n = 4'd1; cmd.address.tag = TAG_W'(9); cmd.address.set_index = SET_W'(2); cmd.address.offset = '0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (read_enable !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_read: got re=%b want 1", read_enable); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_rc = '0; m_wc = '0; m_hc = '0; m_mc = '0;
        n_cmp++; if (cmd_ready !== 1'b1 || read_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got ready=%b re=%b want 1 0", cmd_ready, read_enable); end
        bad_we = write_enable ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (write_enable || !cmd_ready) bad_we++;
        end
        n_cmp++; if (bad_we !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d busy/write cycles want 0", bad_we); end
        for (int w = 0; w < WAYS; w++) begin
            n_cmp++; if (mem[2][w].mesi !== m_mesi[2][w] || mem[2][w].tag !== m_tag[2][w])
                begin n_fail++; $display("FAIL rstmid_set way%0d: got mesi=%0d tag=%0d want %0d %0d", w, mem[2][w].mesi, mem[2][w].tag, m_mesi[2][w], m_tag[2][w]); end
        end
    endtask

    task automatic test_random_traffic();
        int r, s, tag;
        logic [3:0] n;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25) n = 4'd0; else if (r < 45) n = 4'd1; else if (r < 55) n = 4'd2;
            else if (r < 70) n = 4'd3; else if (r < 85) n = 4'd4; else if (r < 93) n = 4'd9;
            else if (r < 96) n = 4'd8;
            else n = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(5, 7)) : 4'($urandom_range(10, 15));
            s = $urandom_range(0, 3);
            tag = $urandom_range(0, 11);
            run_cmd(n, s, tag, lat, nre, nwe, nhit, nmiss, nboth, nrdy, wn);
            model_cmd(n, s, tag, e_hit, e_miss, e_re, e_we, e_lat);
            n_cmp++; if (lat !== e_lat || nhit !== int'(e_hit) || nmiss !== int'(e_miss) || nre !== int'(e_re) || nwe !== int'(e_we) || nboth !== 0)
                begin n_fail++; $display("FAIL rand%0d_n%0d_flow: got lat=%0d hit=%0d miss=%0d re=%0d we=%0d both=%0d want %0d %0d %0d %0d %0d 0",
                    i, n, lat, nhit, nmiss, nre, nwe, nboth, e_lat, e_hit, e_miss, e_re, e_we); end
            n_cmp++; if (nrdy !== ((e_re || n == 4'd8) ? 0 : 1)) begin n_fail++; $display("FAIL rand%0d_ready_busy: got %0d ready cycles", i, nrdy); end
            for (int w = 0; w < WAYS; w++) begin
                n_cmp++;
                if (mem[s][w].mesi !== m_mesi[s][w] || mem[s][w].tag !== m_tag[s][w] || mem[s][w].data !== m_data[s][w] || int'(mem[s][w].lru) !== rank_of(s, w))
                    begin n_fail++; $display("FAIL rand%0d_set%0d_way%0d: got mesi=%0d tag=%0d lru=%0d data=%h want %0d %0d %0d %h",
                        i, s, w, mem[s][w].mesi, mem[s][w].tag, mem[s][w].lru, mem[s][w].data, m_mesi[s][w], m_tag[s][w], rank_of(s, w), m_data[s][w]); end
            end
            n_cmp++;
            if (read_count !== (STATS ? m_rc : 32'd0) || write_count !== (STATS ? m_wc : 32'd0) ||
                hit_count !== (STATS ? m_hc : 32'd0) || miss_count !== (STATS ? m_mc : 32'd0))
                begin n_fail++; $display("FAIL rand%0d_counters: got %0d %0d %0d %0d want %0d %0d %0d %0d", i, read_count, write_count, hit_count, miss_count,
                    STATS ? m_rc : 0, STATS ? m_wc : 0, STATS ? m_hc : 0, STATS ? m_mc : 0); end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; tick = 0;
        m_rc = '0; m_wc = '0; m_hc = '0; m_mc = '0;
        rst = 1'b1; mem_init = 1'b1; cmd_valid = 1'b0; cmd = '0;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < WAYS; w++) begin
                init_set[s][w].mesi = MESI_I;
                init_set[s][w].lru  = LRU_W'(w);
                init_set[s][w].tag  = TAG_W'($urandom);
                init_set[s][w].data = $urandom;
                m_mesi[s][w]  = MESI_I;
                m_tag[s][w]   = init_set[s][w].tag;
                m_data[s][w]  = init_set[s][w].data;
                m_stamp[s][w] = -w;
            end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; mem_init = 1'b0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_evict();
        test_mesi();
        test_n9_n8();
        test_unknown();
        test_reset_mid();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
